packet_injector: RTL
====================

Name: packet_injector

Overview:
- Sits directly downstream of the packet fetch stage and upstream of the data-driven pipeline entry.
- Sequences fetches: pulses the fetch stage's send strobe, captures the 38-bit packet that appears, and buffers it in a small FIFO.
- Presents buffered packets to the pipeline on a valid/ready handshake.
- Stops at the first null packet (header 3'b000) or after MAX_PKTS packets, whichever comes first.

Parameters:
- FIFO_DEPTH, 4: packet buffer entries; power of two, 2..16.
- MAX_PKTS, 20: maximum fetches per run; matches the fetch-stage table size.
- GAP, 0: idle cycles inserted after each capture before the next fetch request.

Ports:
- CLK  input  1  system clock; all state on rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- START  input  1  one-cycle pulse; begins a run when in IDLE or DONE.
- FETCH_REQ  output  1  send strobe to the fetch stage; one-cycle high pulse per fetch.
- FETCH_RST  output  1  reset to the fetch stage's program counter; one-cycle high pulse.
- PACKET_IN  input  38  packet from the fetch stage.
- OUT_VALID  output  1  FIFO head is valid.
- OUT_READY  input  1  pipeline accepts the head.
- OUT_PACKET  output  38  FIFO head packet.
- BUSY  output  1  high from START accept until DONE is entered.
- DONE  output  1  high in DONE state until the next START.

Behaviour:
- Reset (async on RST_N low):
  - State IDLE; FIFO emptied; counters cleared.
  - FETCH_REQ=0, FETCH_RST=0, OUT_VALID=0, OUT_PACKET=0, BUSY=0, DONE=0.
- Packet fields:
  - [37:35] header; 3'b000 marks the null/end packet.
  - [34:27] reserved.
  - [26:20] destination node.
  - [19:16] flags.
  - [15:0] data.
  - The block does not interpret fields other than the header.
- IDLE: on START -> CLEAR. FETCH_RST=1 for exactly that one cycle. BUSY=1. Packet count cleared.
- CLEAR -> REQ, unconditionally.
- REQ:
  - If FIFO not full: FETCH_REQ=1 for one cycle -> CAPT.
  - If FIFO full: stay, FETCH_REQ=0.
- CAPT:
  - Sample PACKET_IN (the fetch-stage output has settled one cycle after the strobe).
  - If header==3'b000 -> DONE; packet not written.
  - Else write the packet into the FIFO, increment the count, then:
    - -> DONE if count reaches MAX_PKTS.
    - -> WAIT if GAP>0.
    - -> REQ otherwise.
- WAIT: count GAP cycles, then -> REQ.
- DONE:
  - BUSY=0 and DONE=1, but only once the FIFO has drained. Until then BUSY stays 1 and DONE stays 0.
  - START in DONE starts a new run (-> CLEAR) even if undrained entries remain; those entries are kept and delivered first.
- START outside IDLE/DONE is ignored.
- FIFO handshake:
  - A transfer occurs on a cycle with OUT_VALID && OUT_READY.
  - OUT_PACKET and OUT_VALID come from registers; OUT_PACKET holds stable while OUT_VALID=1 and OUT_READY=0.
  - First-word latency: a packet written in CAPT at edge N has OUT_VALID=1 after edge N+1.
- Boundary cases:
  - Simultaneous write and read when full: the read frees an entry, but REQ evaluates fullness registered, so no write occurs that cycle. Never overflow.
  - Simultaneous write and read when empty: the written packet appears next cycle. No combinational bypass.
  - Read pointer and write pointer wrap modulo FIFO_DEPTH. Full and empty are distinguished by a count register.
  - RST_N low mid-run: immediate return to the reset state; the FIFO contents are lost.
  - FETCH_REQ is never asserted in two consecutive cycles.

Optional Feature:
- Macro INJECT_STATS_EN.
- When defined:
  - Adds output PKT_SENT[7:0], counting OUT handshakes, saturating at 255.
  - Adds output STALL_CYC[15:0], counting cycles with OUT_VALID=1 and OUT_READY=0, saturating at 65535.
  - Both clear on reset and on START accept.
- When undefined: neither port nor its logic exists; all other behaviour is identical.

Test Plan:
- Fetch model holds 4 valid packets then nulls; START with OUT_READY=1 -> FETCH_RST pulses once, then 4 FETCH_REQ pulses. Packets appear on OUT_PACKET in order 0,1,2,3; then a fifth fetch returns a null; DONE=1 and BUSY=0.
- FIFO_DEPTH=4, OUT_READY=0, 10 valid packets -> exactly 4 FETCH_REQ pulses, then REQ stalls. Raising OUT_READY resumes fetching. All 10 delivered in order with no loss or duplication.
- MAX_PKTS=3 with all table entries valid -> exactly 3 packets delivered, then DONE, with no fourth FETCH_REQ.
- GAP=2 -> FETCH_REQ pulses exactly 4 cycles apart (REQ, CAPT, 2 WAIT).
- Drop RST_N mid-run with 2 entries buffered -> all outputs 0 immediately. After release, START restarts from packet 0.
- With INJECT_STATS_EN defined: 4 packets delivered and OUT_READY held low 5 cycles while valid -> PKT_SENT=4, STALL_CYC=5.

Source files
------------

// File: rtl/packet_injector.sv
// packet_injector: sequences fetch-stage reads into a FIFO and streams packets out on valid/ready (optional stats: INJECT_STATS_EN)
module packet_injector #(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_PKTS = 20,
  parameter int GAP = 0
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  output logic        FETCH_REQ,
  output logic        FETCH_RST,
  input  logic [37:0] PACKET_IN,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic [37:0] OUT_PACKET,
  output logic        BUSY,
  output logic        DONE
`ifdef INJECT_STATS_EN
  ,
  output logic [7:0]  PKT_SENT,
  output logic [15:0] STALL_CYC
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int NW = $clog2(MAX_PKTS + 1);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_REQ, S_CAPT, S_WAIT, S_DONE} state_t;
  state_t state, nxt;
  logic [37:0] mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, mem_n;
  logic [NW-1:0] pkt_cnt;
  logic [GW-1:0] gap_cnt;
  logic full, empty, start_acc, wr, xfer, load;
  // cnt covers every held packet including the output register, so full/empty never alias
  assign full = cnt == CW'(FIFO_DEPTH);
  assign empty = cnt == '0;
  assign start_acc = START && (state == S_IDLE || state == S_DONE);
  assign wr = state == S_CAPT && PACKET_IN[37:35] != 3'b000;
  assign xfer = OUT_VALID && OUT_READY;
  assign mem_n = cnt - CW'(OUT_VALID);
  assign load = mem_n != '0 && (!OUT_VALID || OUT_READY);
  // next-state and strobes; fullness is the registered count so no write lands on a full buffer
  always_comb begin
    nxt = state;
    FETCH_REQ = state == S_REQ && !full;
    FETCH_RST = state == S_CLEAR;
    BUSY = state != S_IDLE && !(state == S_DONE && empty);
    DONE = state == S_DONE && empty;
    case (state)
      S_IDLE:  nxt = start_acc ? S_CLEAR : S_IDLE;
      S_CLEAR: nxt = S_REQ;
      S_REQ:   nxt = full ? S_REQ : S_CAPT;
      S_CAPT:  nxt = !wr ? S_DONE : (pkt_cnt == NW'(MAX_PKTS - 1)) ? S_DONE : (GAP > 0) ? S_WAIT : S_REQ;
      S_WAIT:  nxt = (gap_cnt == GW'(GAP - 1)) ? S_REQ : S_WAIT;
      S_DONE:  nxt = START ? S_CLEAR : S_DONE;
      default: nxt = S_IDLE;
    endcase
  end
  // state register plus run and gap counters
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= S_IDLE;
      pkt_cnt <= '0;
      gap_cnt <= '0;
    end else begin
      state <= nxt;
      pkt_cnt <= start_acc ? '0 : wr ? pkt_cnt + 1'b1 : pkt_cnt;
      gap_cnt <= (state == S_WAIT) ? gap_cnt + 1'b1 : '0;
    end
  end
  // buffer storage needs no reset; occupancy is tracked by cnt
  always_ff @(posedge CLK) begin
    if (wr) mem[wr_ptr] <= PACKET_IN;
  end
  // pointers, occupancy and the registered head that drives the output port
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
      OUT_VALID <= 1'b0;
      OUT_PACKET <= '0;
    end else begin
      wr_ptr <= wr ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr <= load ? rd_ptr + 1'b1 : rd_ptr;
      cnt <= cnt + CW'(wr) - CW'(xfer);
      OUT_VALID <= load ? 1'b1 : xfer ? 1'b0 : OUT_VALID;
      OUT_PACKET <= load ? mem[rd_ptr] : OUT_PACKET;
    end
  end
`ifdef INJECT_STATS_EN
  // saturating handshake and stall counters, cleared when a run is accepted
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PKT_SENT <= '0;
      STALL_CYC <= '0;
    end else if (start_acc) begin
      PKT_SENT <= '0;
      STALL_CYC <= '0;
    end else begin
      PKT_SENT <= (xfer && PKT_SENT != 8'hff) ? PKT_SENT + 1'b1 : PKT_SENT;
      STALL_CYC <= (OUT_VALID && !OUT_READY && STALL_CYC != 16'hffff) ? STALL_CYC + 1'b1 : STALL_CYC;
    end
  end
`endif
endmodule
